// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared fetch-stage encodings, constants and helpers
package fetch_pc_unit_pkg;

    // Fetch sequencer states: BOOT lasts one cycle after reset, RUN thereafter.
    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] INSN_BYTES       = 32'd4;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h4000_0000;

    // Instructions are word aligned; low address bits of a target are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(INSN_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_perf_counter.sv
// rtl/fetch_pc_unit_perf_counter.sv - wrapping event counter with increment enable
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one per qualifying cycle; overflow wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage PC generator with stall/kill/redirect handling
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             kill,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    output logic             imem_en,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic             if_valid,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_kill
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus4;
    logic         running;
    logic         redirect_take;
    logic         fetch_inc;
    logic         stall_inc;
    logic         kill_inc;

    assign running       = (state_q == FETCH_RUN);
    assign pc_plus4      = pc_q + INSN_BYTES;
    // A redirect is only honoured when the pipeline is moving; under stall it is dropped.
    assign redirect_take = running & redirect_valid & ~stall;

    // Next-PC selection: stall holds, then redirect, then sequential fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
                pc_d    = PC_RESET;
                valid_d = 1'b1;
            end
            FETCH_RUN: begin
                if (stall) begin
                    pc_d    = pc_q;
                    valid_d = valid_q;
                end else if (redirect_valid) begin
                    pc_d    = align_word(redirect_target);
                    valid_d = 1'b1;
                end else begin
                    pc_d    = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_BOOT;
                pc_d    = PC_RESET;
                valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state plus the PC/valid of the word that will be on the IMEM bus next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_BOOT;
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // The address issued now is exactly the PC that will own the returned word.
    assign imem_addr   = pc_d;
    assign imem_en     = 1'b1;
    assign if_pc       = pc_q;
    assign if_pc_plus4 = pc_plus4;
    assign if_valid    = valid_q & ~kill & ~redirect_take;

    assign fetch_inc = if_valid & ~stall;
    assign stall_inc = running & stall;
    // Kill and redirect together still count once; a stalled word is not lost so it is not counted.
    assign kill_inc  = running & valid_q & ~stall & (kill | redirect_valid);

    perf_counter #(.CNT_W(CNT_W)) u_cnt_fetch (
        .clk   (clk),
        .rst   (rst),
        .inc   (fetch_inc),
        .count (cnt_fetch)
    );

    perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (cnt_stall)
    );

    perf_counter #(.CNT_W(CNT_W)) u_cnt_kill (
        .clk   (clk),
        .rst   (rst),
        .inc   (kill_inc),
        .count (cnt_kill)
    );

endmodule
